// File: rtl/neuron_lut_loader.sv
// Runtime-loadable LogicNet neuron truth table: streams 2^IN_BITS entries in listing
// order over a valid/ready port, then serves one-cycle registered lookups.
module neuron_lut_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [OUT_BITS-1:0] ld_data,
  output logic                load_done,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_addr,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                lookup_err
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t              state, state_nxt;
  logic [IN_BITS:0]    cnt;
  logic [OUT_BITS-1:0] lut [DEPTH];
  logic                wr_en, cnt_clr, last_beat, serve;

  // Listing order has the MSB of the address changing fastest.
  function automatic logic [IN_BITS-1:0] bitrev(input logic [IN_BITS-1:0] k);
    logic [IN_BITS-1:0] r;
    for (int i = 0; i < IN_BITS; i++) r[i] = k[IN_BITS-1-i];
    return r;
  endfunction

  assign last_beat = (cnt == (IN_BITS+1)'(DEPTH - 1));
  assign serve     = in_valid && (state == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    load_done = 1'b0;
    wr_en     = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
          cnt_clr   = 1'b1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        // A restart discards any beat handshaking in the same cycle.
        if (load_start) begin
          cnt_clr = 1'b1;
        end else if (ld_valid) begin
          wr_en = 1'b1;
          if (last_beat) begin
            state_nxt = READY;
            cnt_clr   = 1'b1;
          end
        end
      end
      READY: begin
        load_done = 1'b1;
        if (load_start) begin
          state_nxt = LOAD;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (wr_en)   cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (wr_en) begin
      lut[bitrev(cnt[IN_BITS-1:0])] <= ld_data;
    end
  end

  // Lookup stage: one-cycle registered read, result held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      lookup_err <= 1'b0;
    end else begin
      out_valid <= serve;
      if (serve) out_data <= lut[in_addr];
      if (in_valid && (state != READY)) lookup_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Randomised bench for neuron_lut_loader against an array model of the truth table
// indexed by the bit-reversed beat number.
module tb_neuron_lut_loader;
  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int DEPTH    = 1 << IN_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0, ld_valid = 1'b0, in_valid = 1'b0;
  logic [OUT_BITS-1:0] ld_data = '0;
  logic [IN_BITS-1:0]  in_addr = '0;
  logic ld_ready, load_done, out_valid, lookup_err;
  logic [OUT_BITS-1:0] out_data;

  logic [OUT_BITS-1:0] model  [DEPTH];
  logic [OUT_BITS-1:0] stream [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  neuron_lut_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .load_done(load_done),
    .in_valid(in_valid), .in_addr(in_addr), .out_valid(out_valid),
    .out_data(out_data), .lookup_err(lookup_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < IN_BITS; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic random_stream();
    for (int i = 0; i < DEPTH; i++) stream[i] = OUT_BITS'($urandom_range(0, (1 << OUT_BITS) - 1));
  endtask

  // Feeds stream[] from beat 0; optionally restarts or resets at a given beat index.
  task automatic feed_beats(input int gap_pct, input int restart_at, input int reset_at);
    int k = 0;
    int cyc = 0;
    bit hs;
    while (k < DEPTH && cyc < 2000) begin
      cyc++;
      ld_valid = ($urandom_range(0, 99) >= gap_pct);
      ld_data  = stream[k];
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        ld_valid = 1'b0;
        return;
      end
      if (k == restart_at) begin
        ld_valid = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b0;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ld_ready got %0b want 1", ld_ready); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL restart_load_done got %0b want 0", load_done); end
        return;
      end
      hs = ld_valid && ld_ready;
      if (hs && k == DEPTH - 1) begin
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL early_load_done got %0b want 0", load_done); end
      end
      tick();
      if (hs) begin
        model[rev(k)] = stream[k];
        k++;
      end
    end
    ld_valid = 1'b0;
    n_cmp++;
    if (k != DEPTH) begin
      n_bad++; $display("FAIL load_timeout beats got %0d want %0d", k, DEPTH);
    end else begin
      if (load_done !== 1'b1) begin n_bad++; $display("FAIL load_done_rise got %0b want 1", load_done); end
      n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL ld_ready_fall got %0b want 0", ld_ready); end
    end
  endtask

  task automatic start_load(input int gap_pct);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready_rise got %0b want 1", ld_ready); end
    feed_beats(gap_pct, -1, -1);
  endtask

  task automatic sweep_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1;
      in_addr  = a[IN_BITS-1:0];
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== model[a])
        begin n_bad++; $display("FAIL %s addr %0d got v%0b d%0d want v1 d%0d", tag, a, out_valid, out_data, model[a]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready got %0b want 0", ld_ready); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done got %0b want 0", load_done); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if (lookup_err !== 1'b0) begin n_bad++; $display("FAIL reset_lookup_err got %0b want 0", lookup_err); end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick();
  endtask

  task automatic test_early_lookup();
    in_valid = 1'b1;
    in_addr  = '0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL early_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (lookup_err !== 1'b1) begin n_bad++; $display("FAIL early_lookup_err got %0b want 1", lookup_err); end
  endtask

  task automatic test_basic_load();
    logic [IN_BITS-1:0]  addrs [4];
    logic [OUT_BITS-1:0] exps  [4];
    addrs = '{6'b000000, 6'b100000, 6'b010000, 6'b110000};
    exps  = '{2'b10, 2'b00, 2'b11, 2'b10};
    random_stream();
    for (int i = 0; i < 4; i++) stream[i] = exps[i];
    start_load(0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = addrs[i];
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exps[i])
        begin n_bad++; $display("FAIL first_beats addr %b got v%0b d%b want v1 d%b", addrs[i], out_valid, out_data, exps[i]); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== exps[3])
      begin n_bad++; $display("FAIL hold got v%0b d%b want v0 d%b", out_valid, out_data, exps[3]); end
    n_cmp++; if (lookup_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %0b want 1", lookup_err); end
  endtask

  task automatic test_back_to_back();
    sweep_all("back_to_back");
  endtask

  task automatic test_restart();
    random_stream();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    feed_beats(30, 20, -1);
    random_stream();
    feed_beats(30, -1, -1);
    sweep_all("restart");
  endtask

  task automatic test_reset_mid_load();
    random_stream();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    feed_beats(20, -1, 30);
    n_cmp++; if (load_done !== 1'b0 || ld_ready !== 1'b0 || out_data !== '0 || lookup_err !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset got done%0b rdy%0b d%0d err%0b want 0000", load_done, ld_ready, out_data, lookup_err); end
    tick();
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_idle ld_ready got %0b want 0", ld_ready); end
    for (int i = 0; i < DEPTH; i++) stream[i] = '0;
    start_load(20);
    sweep_all("zero_reload");
  endtask

  task automatic test_ready_restart();
    logic [OUT_BITS-1:0] old;
    random_stream();
    start_load(10);
    old = model[32];
    in_valid   = 1'b1;
    in_addr    = 6'b100000;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    in_valid   = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== old)
      begin n_bad++; $display("FAIL ready_restart_lookup got v%0b d%0d want v1 d%0d", out_valid, out_data, old); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL ready_restart_done got %0b want 0", load_done); end
    n_cmp++; if (lookup_err !== 1'b0) begin n_bad++; $display("FAIL ready_restart_err got %0b want 0", lookup_err); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || lookup_err !== 1'b1)
      begin n_bad++; $display("FAIL load_lookup got v%0b err%0b want v0 err1", out_valid, lookup_err); end
    random_stream();
    feed_beats(10, -1, -1);
    sweep_all("final");
  endtask

  initial begin
    test_reset();
    test_early_lookup();
    test_basic_load();
    test_back_to_back();
    test_restart();
    test_reset_mid_load();
    test_ready_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_lut_loader.md
# neuron_lut_loader

Runtime-programmable LogicNet neuron truth table, the write-side counterpart of the fixed generated neuron ROMs. It accepts a streamed truth table of 2^IN_BITS entries over a valid/ready load port and stores it in a register array. After loading, it serves registered lookups with the same address/data semantics as a generated neuron: a packed fan-in word in, a quantised activation out. It sits beside the generated layers, so that neuron functions can be swapped on the bench or in-system without resynthesis.

## Interface
- IN_BITS, 6, lookup address width (fan-in × input bit-width); table depth is 2^IN_BITS
- OUT_BITS, 2, stored entry and activation width
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle request to begin or restart a table load
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready
- ld_data  in  OUT_BITS  table entry for the current beat
- load_done  out  1  level, high while a complete table is held
- in_valid  in  1  lookup request
- in_addr  in  IN_BITS  lookup address (packed neuron inputs, M0 convention)
- out_valid  out  1  lookup result valid
- out_data  out  OUT_BITS  lookup result
- lookup_err  out  1  sticky: a lookup arrived while load_done was low

## Operation
- States are IDLE, LOAD and READY. Reset enters IDLE.
- Reset clears all table entries to 0, clears the beat counter (IN_BITS+1 bits wide), and drives every output to 0.
- IDLE: load_start moves to LOAD. ld_ready=0.
- LOAD: ld_ready=1.
  - Each handshake writes ld_data to address bitrev(k), where k is the beat index 0..2^IN_BITS-1. This is truth-table listing order, with in_addr[IN_BITS-1] the fastest-changing bit: beat 0 → 6'b000000, beat 1 → 6'b100000, beat 2 → 6'b010000.
  - After the beat with k=2^IN_BITS-1, the next state is READY.
- READY: ld_ready=0 and load_done=1. load_start moves to LOAD. The table keeps its contents until overwritten beat by beat.
- load_start while in LOAD restarts the load. The counter returns to 0, and a beat handshaking in the same cycle is discarded (not written).
- load_start while in READY: load_done drops the following cycle, and the old table contents stay in place until overwritten.
- Lookup:
  - When in_valid is high and state is READY, the block registers table[in_addr] into out_data and pulses out_valid.
  - When in_valid is high in IDLE or LOAD, no out_valid is produced and lookup_err is set. Only reset clears lookup_err.
  - A lookup in the same cycle as load_start in READY is still served, and reads pre-load contents.
- out_data holds its last value while out_valid is low.
- There is no backpressure on the lookup path, so one lookup per cycle is sustained.

## Timing
- Load throughput: one beat per cycle. A full load takes 2^IN_BITS handshake cycles (64 at defaults).
- load_done rises one cycle after the final beat's handshake edge.
- ld_ready rises one cycle after load_start is sampled in IDLE or READY.
- ld_ready falls on the cycle after the final beat.
- Lookup latency is 1 cycle: out_valid and out_data are valid the cycle after in_valid is sampled.
- Reset mid-load: the partial table is cleared, the state is IDLE, and load_done=0. Loading must restart.
- The ld_valid low gaps are tolerated in LOAD. The counter advances only on handshake.

## Test plan
- Reset, then check every output: all outputs 0, ld_ready=0, load_done=0.
- Issue a lookup in_addr=6'b000000 → no out_valid, and lookup_err=1 stays high through the later tests.
- Load a 64-entry table whose first beats are 2'b10, 2'b00, 2'b11, 2'b10.
  - load_done rises exactly 1 cycle after beat 63.
  - Lookup 6'b000000 → 2'b10, 6'b100000 → 2'b00, 6'b010000 → 2'b11, 6'b110000 → 2'b10, each 1 cycle later.
- Issue back-to-back lookups over all 64 addresses with in_valid held high → 64 consecutive out_valid cycles matching the bit-reversed model.
- Load with random ld_valid gaps, then assert load_start at beat 20 while ld_valid=1 → that beat is not written, the counter restarts, and the final table equals the second stream only.
- Assert rst_n low at beat 30 → table reads all zero after a reload of zeros.
- Assert load_start in READY together with a lookup of 6'b100000 → the lookup returns the old value, then load_done=0 the next cycle.
